// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, fetch state enum and fetch queue entry type
package cpu_pkg;
    localparam int PC_W = 8;
    localparam int INSTR_W = 16;
    localparam logic [1:0] FETCH_DEPTH = 2'd2;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JZ = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1110;

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] w);
        return w[15:12] == OP_HLT;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry in-order {pc, word} FIFO with push/pop/flush; entry 0 is the head
module fetch_queue
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [PC_W-1:0]     din_pc,
    input  logic [INSTR_W-1:0]  din_word,
    output logic [PC_W-1:0]     head_pc,
    output logic [INSTR_W-1:0]  head_word,
    output logic [1:0]          count
);
    fetch_entry_t e0_q, e0_d, e1_q, e1_d, din;
    logic [1:0] count_q, count_d;

    always_comb begin
        din = '{pc: din_pc, word: din_word};
        e0_d = e0_q;
        e1_d = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (pop && push) begin
            e0_d = (count_q == 2'd1) ? din : e1_q;
            e1_d = (count_q == 2'd1) ? e1_q : din;
        end else if (pop) begin
            e0_d = e1_q;
            count_d = count_q - 2'd1;
        end else if (push) begin
            e0_d = (count_q == 2'd0) ? din : e0_q;
            e1_d = (count_q == 2'd0) ? e1_q : din;
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q <= '0;
            e1_q <= '0;
            count_q <= '0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            count_q <= count_d;
        end
    end

    assign head_pc = e0_q.pc;
    assign head_word = e0_q.word;
    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, HLT stop/halt state and redirect flush around a 2-entry fetch queue
module fetch_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    output logic        halted
);
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic fetch_stop_q, fetch_stop_d;
    state_t state_q, state_d;
    logic push, pop, redir;
    logic [1:0] count;

    fetch_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redir),
        .din_pc    (fetch_pc_q),
        .din_word  (imem_data),
        .head_pc   (instr_pc),
        .head_word (instr_out),
        .count     (count)
    );

    // A pop coincident with redirect still completes; the flush only drops what is left.
    always_comb begin
        redir = redirect && state_q == RUN;
        instr_valid = state_q == RUN && count != 2'd0;
        pop = instr_valid && instr_ready;
        push = state_q == RUN && !fetch_stop_q && !redir && (count < FETCH_DEPTH || pop);
        fetch_pc_d = redir ? redirect_addr : push ? fetch_pc_q + 8'd1 : fetch_pc_q;
        fetch_stop_d = redir ? 1'b0 : (push && is_hlt(imem_data)) ? 1'b1 : fetch_stop_q;
        state_d = (pop && !redir && is_hlt(instr_out)) ? HALTED : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
            fetch_stop_q <= 1'b0;
            state_q <= RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fetch_stop_q <= fetch_stop_d;
            state_q <= state_d;
        end
    end

    assign imem_addr = {8'h00, fetch_pc_q};
    assign halted = state_q == HALTED;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; stimulus queues expected {pc, word}, a monitor checks every pop
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr, imem_data, instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid, instr_ready = 1'b0, redirect = 1'b0, halted;
    logic [7:0]  redirect_addr = 8'h00;
    logic        mon_en = 1'b0;

    logic [15:0] imem [256];
    logic [15:0] demo [8];
    logic [23:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halted        (halted)
    );

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en && rst_n && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got pc %h word %h, expected nothing", instr_pc, instr_out);
            end else if ({instr_pc, instr_out} !== exp_q[0]) begin
                errors++;
                $display("FAIL pop: got pc %h word %h, expected pc %h word %h",
                         instr_pc, instr_out, exp_q[0][23:16], exp_q[0][15:0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [7:0] pc);
        exp_q.push_back({pc, imem[pc]});
    endtask

    task automatic expect_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) expect_pc(8'(i));
    endtask

    task automatic load_demo();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) imem[i] = demo[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'h0000);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_instr_out"}, 32'(instr_out), 32'h0000);
        check({tag, "_instr_pc"}, 32'(instr_pc), 32'h00);
        check({tag, "_halted"}, 32'(halted), 32'h0);
    endtask

    // Leaves the bench just after the first rising edge with rst_n=1.
    task automatic do_reset();
        rst_n = 1'b0;
        mon_en = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 40 && !halted; i++) tick();
        check({name, "_halt_reached"}, 32'(halted), 32'h1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_scoreboard_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        demo[0] = 16'h9005; demo[1] = 16'h9403; demo[2] = 16'h1100; demo[3] = 16'h9802;
        demo[4] = 16'h2200; demo[5] = 16'h9C00; demo[6] = 16'hB300; demo[7] = 16'hE000;
        load_demo();
        #2;
        check_reset_outputs("por");

        // Demo program, free-flowing decode: pc k popped at edge k+2, halt after pc 7.
        rst_n = 1'b0;
        expect_range(0, 7);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("first_valid", 32'(instr_valid), 32'h1);
        check("first_pc", 32'(instr_pc), 32'h00);
        for (int i = 0; i < 7; i++) tick();
        check("demo_not_halted_yet", 32'(halted), 32'h0);
        tick();
        check("demo_halted", 32'(halted), 32'h1);
        check("demo_valid_off", 32'(instr_valid), 32'h0);
        check("demo_imem_frozen", 32'(imem_addr), 32'h0008);
        tick();
        check("demo_still_frozen", 32'(imem_addr), 32'h0008);
        check_drained("demo");

        // Backpressure for 5 cycles, then back-to-back delivery.
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        check("bp_imem_addr", 32'(imem_addr), 32'h0002);
        check("bp_instr_out", 32'(instr_out), 32'h9005);
        check("bp_instr_pc", 32'(instr_pc), 32'h00);
        expect_range(0, 7);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_b2b_valid", 32'(instr_valid), 32'h1);
            check("bp_b2b_pc", 32'(instr_pc), 32'(i));
            tick();
        end
        wait_halt("bp");
        check_drained("bp");

        // Redirect to 5 while pc 1 is at the head and being popped.
        do_reset();
        expect_pc(8'h00); expect_pc(8'h01); expect_range(5, 7);
        instr_ready = 1'b1;
        tick();
        check("rd_head_pc1", 32'(instr_pc), 32'h01);
        redirect = 1'b1;
        redirect_addr = 8'h05;
        tick();
        redirect = 1'b0;
        check("rd_bubble", 32'(instr_valid), 32'h0);
        tick();
        check("rd_target_valid", 32'(instr_valid), 32'h1);
        check("rd_target_pc", 32'(instr_pc), 32'h05);
        check("rd_target_word", 32'(instr_out), 32'h9C00);
        wait_halt("rd");
        check_drained("rd");

        // All-NOP image, redirect to 8'hFF: delivery wraps FF, 00, 01.
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        do_reset();
        expect_pc(8'h00); expect_pc(8'hFF); expect_pc(8'h00); expect_pc(8'h01);
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 8'hFF;
        tick();
        redirect = 1'b0;
        check("wrap_bubble", 32'(instr_valid), 32'h0);
        tick();
        check("wrap_head_ff", 32'(instr_pc), 32'hFF);
        check("wrap_imem_addr", 32'(imem_addr), 32'h0000);
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        check_drained("wrap");

        // Redirect to 0 with HLT queued and unpopped: no halt, refetch from 0.
        load_demo();
        do_reset();
        expect_range(0, 6);
        instr_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        instr_ready = 1'b0;
        check("hr_hlt_at_head", 32'(instr_out), 32'hE000);
        redirect = 1'b1;
        redirect_addr = 8'h00;
        tick();
        redirect = 1'b0;
        check("hr_no_halt", 32'(halted), 32'h0);
        check("hr_imem_addr", 32'(imem_addr), 32'h0000);
        check("hr_flushed", 32'(instr_valid), 32'h0);
        expect_range(0, 7);
        instr_ready = 1'b1;
        wait_halt("hr");
        check_drained("hr");

        // Asynchronous reset pulse mid-stream, then refetch from pc 0.
        do_reset();
        expect_range(0, 2);
        instr_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async");
        #3;
        rst_n = 1'b1;
        expect_range(0, 7);
        mon_en = 1'b1;
        tick();
        check("async_refetch_pc", 32'(instr_pc), 32'h00);
        check("async_refetch_valid", 32'(instr_valid), 32'h1);
        wait_halt("async");
        check_drained("async");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
